// File: rtl/noc_out_arb_5to1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types and constants for the NOC output-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int NUM_PORTS = 5;

    // Input port index encoding
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef logic [FLIT_W-1:0] flit_t;

    // Arbiter FSM: pick a packet, then hold it until the tail passes
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // One-hot vector for a port index
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_out_arb_5to1_rr_pick5.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick5
// Description : Combinational round-robin picker over five requesters.
//               Scans last+1, last+2, ... (mod 5) and returns the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] last,
    output logic [2:0] gnt_idx,
    output logic       any
);

    logic [3:0] w_sum;

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after the pointer overwrites the others and wins.
    always_comb begin
        gnt_idx = 3'd0;
        any     = |req;
        w_sum   = 4'd0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_sum = {1'b0, last} + 4'(k);
            if (w_sum >= 4'd5) begin
                w_sum = w_sum - 4'd5;
            end
            if (req[w_sum[2:0]]) begin
                gnt_idx = w_sum[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_out_arb_5to1.sv
`default_nettype none
// ============================================================================
// Module      : noc_out_arb_5to1
// Description : NOC router output port. Round-robin arbitrates among five
//               inputs, locks the winner for a whole wormhole packet and
//               drives a registered flit under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_out_arb_5to1
    import noc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        req_i,
    input  logic [4:0]        tail_i,
    input  logic [FLIT_W-1:0] data_n_i,
    input  logic [FLIT_W-1:0] data_s_i,
    input  logic [FLIT_W-1:0] data_w_i,
    input  logic [FLIT_W-1:0] data_e_i,
    input  logic [FLIT_W-1:0] data_l_i,
    output logic [4:0]        grant_o,
    output logic [FLIT_W-1:0] data_o,
    output logic              valid_o,
    output logic              tail_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic [2:0]        owner_o
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic [2:0] r_last;
    logic [2:0] r_owner;
    flit_t      r_data;
    logic       r_valid;
    logic       r_tail;

    logic [2:0] w_pick_idx;
    logic       w_pick_any;
    flit_t      w_sel_data;
    logic       w_sel_req;
    logic       w_sel_tail;
    logic       w_can_load;
    logic       w_xfer;

    rr_pick5 u_pick (
        .req     (req_i),
        .last    (r_last),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // Output register can take a new flit when empty or draining this cycle
    assign w_can_load = !r_valid || ready_i;

    // Route the locked port's flit, request and tail flag
    always_comb begin
        w_sel_data = data_n_i;
        w_sel_req  = req_i[r_owner];
        w_sel_tail = tail_i[r_owner];
        case (port_e'(r_owner))
            PORT_N:  w_sel_data = data_n_i;
            PORT_S:  w_sel_data = data_s_i;
            PORT_W:  w_sel_data = data_w_i;
            PORT_E:  w_sel_data = data_e_i;
            PORT_L:  w_sel_data = data_l_i;
            default: w_sel_data = data_n_i;
        endcase
    end

    // Next state, transfer strobe and grant pulse
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        grant_o     = 5'b00000;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (w_sel_req && w_can_load) begin
                    w_xfer  = 1'b1;
                    grant_o = port_onehot(r_owner);
                    if (w_sel_tail) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner captured at arbitration; pointer advances when a tail passes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last  <= 3'd4;
            r_owner <= 3'd0;
        end else begin
            if (r_state == ARB_IDLE && w_pick_any) begin
                r_owner <= w_pick_idx;
            end
            if (w_xfer && w_sel_tail) begin
                r_last <= r_owner;
            end
        end
    end

    // Output flit register: load on transfer, otherwise empty on drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_tail  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= w_sel_data;
            r_tail  <= w_sel_tail;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign tail_o  = r_tail;
    assign busy_o  = (r_state == ARB_LOCKED);
    assign owner_o = busy_o ? r_owner : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_noc_out_arb_5to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_out_arb_5to1
// Description : Self-checking bench for noc_out_arb_5to1. Per-port packet
//               queues feed the DUT; a behavioural model is compared with
//               the outputs every cycle, plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_out_arb_5to1;

    typedef struct packed {
        logic [15:0] d;
        logic        t;
    } fl_s;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  req_i = 5'b0;
    logic [4:0]  tail_i = 5'b0;
    logic [15:0] data_n_i = 16'h0, data_s_i = 16'h0, data_w_i = 16'h0;
    logic [15:0] data_e_i = 16'h0, data_l_i = 16'h0;
    logic [4:0]  grant_o;
    logic [15:0] data_o;
    logic        valid_o, tail_o, busy_o;
    logic        ready_i = 1'b1;
    logic [2:0]  owner_o;

    noc_out_arb_5to1 dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .tail_i(tail_i),
        .data_n_i(data_n_i), .data_s_i(data_s_i), .data_w_i(data_w_i),
        .data_e_i(data_e_i), .data_l_i(data_l_i), .grant_o(grant_o),
        .data_o(data_o), .valid_o(valid_o), .tail_o(tail_o),
        .ready_i(ready_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus state
    fl_s         q [5][$];
    logic [4:0]  hold = 5'b0;
    logic        drv_ready = 1'b1;
    bit          rand_mode = 1'b0;
    logic [4:0]  drv_gs;
    logic [15:0] drv_d [5];

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int glog_idx[$];
    int glog_cyc[$];
    int glog_own[$];

    // Behavioural model state
    bit          m_locked;
    int          m_owner;
    int          m_last;
    bit          m_v;
    logic [15:0] m_d;
    bit          m_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_flit(input int p, input logic [15:0] d, input logic t);
        fl_s f;
        f.d = d;
        f.t = t;
        q[p].push_back(f);
    endtask

    task automatic push_rand_pkt(input int p);
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            push_flit(p, 16'($urandom), (i == len - 1));
        end
    endtask

    task automatic clear_log();
        glog_idx.delete();
        glog_cyc.delete();
        glog_own.delete();
    endtask

    // Driver: pop on observed grant, then present queue heads
    initial begin
        forever begin
            @(negedge clk_i);
            drv_gs = grant_o;
            @(posedge clk_i);
            #1;
            for (int p = 0; p < 5; p++) begin
                if (drv_gs[p] && q[p].size() > 0) void'(q[p].pop_front());
            end
            if (rand_mode) begin
                drv_ready = ($urandom_range(0, 3) != 0);
                for (int p = 0; p < 5; p++) begin
                    hold[p] = ($urandom_range(0, 4) == 0);
                    while (q[p].size() < 4) push_rand_pkt(p);
                end
            end
            for (int p = 0; p < 5; p++) begin
                req_i[p]  = (q[p].size() > 0) && !hold[p];
                tail_i[p] = (q[p].size() > 0) ? q[p][0].t : 1'b0;
                drv_d[p]  = (q[p].size() > 0) ? q[p][0].d : 16'h0;
            end
            data_n_i = drv_d[0];
            data_s_i = drv_d[1];
            data_w_i = drv_d[2];
            data_e_i = drv_d[3];
            data_l_i = drv_d[4];
            ready_i  = drv_ready;
        end
    end

    // Model and per-cycle compare
    initial begin
        logic [4:0]  exp_g;
        logic [15:0] din [5];
        bit          can, nv;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (grant_o != 5'b0) begin
                for (int p = 0; p < 5; p++) begin
                    if (grant_o[p]) begin
                        glog_idx.push_back(p);
                        glog_cyc.push_back(cyc);
                        glog_own.push_back(int'(owner_o));
                    end
                end
            end
            if (rst_i) begin
                m_locked = 0; m_owner = 0; m_last = 4;
                m_v = 0; m_d = 16'h0; m_t = 0;
                chk("rst_valid", {31'b0, valid_o}, 32'd0);
                chk("rst_tail",  {31'b0, tail_o},  32'd0);
                chk("rst_data",  {16'b0, data_o},  32'd0);
                chk("rst_grant", {27'b0, grant_o}, 32'd0);
                chk("rst_busy",  {31'b0, busy_o},  32'd0);
                chk("rst_owner", {29'b0, owner_o}, 32'd0);
            end else begin
                din[0] = data_n_i; din[1] = data_s_i; din[2] = data_w_i;
                din[3] = data_e_i; din[4] = data_l_i;
                can   = !m_v || ready_i;
                exp_g = 5'b0;
                if (m_locked && req_i[m_owner] && can) exp_g[m_owner] = 1'b1;
                chk("m_grant", {27'b0, grant_o}, {27'b0, exp_g});
                chk("m_valid", {31'b0, valid_o}, {31'b0, m_v});
                if (m_v) begin
                    chk("m_data", {16'b0, data_o}, {16'b0, m_d});
                    chk("m_tail", {31'b0, tail_o}, {31'b0, m_t});
                end
                chk("m_busy",  {31'b0, busy_o}, {31'b0, m_locked});
                chk("m_owner", {29'b0, owner_o}, m_locked ? 32'(m_owner) : 32'd0);
                nv = m_v;
                if (m_v && ready_i) nv = 0;
                if (m_locked) begin
                    if (exp_g != 5'b0) begin
                        m_d = din[m_owner];
                        m_t = tail_i[m_owner];
                        nv  = 1;
                        if (tail_i[m_owner]) begin
                            m_locked = 0;
                            m_last   = m_owner;
                        end
                    end
                end else if (req_i != 5'b0) begin
                    for (int k = 1; k <= 5; k++) begin
                        if (req_i[(m_last + k) % 5]) begin
                            m_owner = (m_last + k) % 5;
                            break;
                        end
                    end
                    m_locked = 1;
                end
                m_v = nv;
            end
        end
    end

    // Called just after a negedge; returns just after a later negedge
    task automatic do_reset(input bit check_async);
        #2 rst_i = 1'b1;
        #1;
        if (check_async) begin
            chk("async_valid", {31'b0, valid_o}, 32'd0);
            chk("async_busy",  {31'b0, busy_o},  32'd0);
        end
        for (int p = 0; p < 5; p++) q[p].delete();
        hold      = 5'b0;
        drv_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        do_reset(1'b0);

        // 3-flit packet from N
        push_flit(0, 16'hA001, 0); push_flit(0, 16'hA002, 0); push_flit(0, 16'hA003, 1);
        step(); chk("n3_c0_grant", {27'b0, grant_o}, 32'd0);
        step(); chk("n3_c1_grant", {27'b0, grant_o}, 32'd1);
                chk("n3_c1_owner", {29'b0, owner_o}, 32'd0);
        step(); chk("n3_c2_data", {16'b0, data_o}, 32'hA001);
                chk("n3_c2_grant", {27'b0, grant_o}, 32'd1);
        step(); chk("n3_c3_data", {16'b0, data_o}, 32'hA002);
                chk("n3_c3_grant", {27'b0, grant_o}, 32'd1);
        step(); chk("n3_c4_data", {16'b0, data_o}, 32'hA003);
                chk("n3_c4_tail", {31'b0, tail_o}, 32'd1);
                chk("n3_c4_busy", {31'b0, busy_o}, 32'd0);
        step(); chk("n3_c5_valid", {31'b0, valid_o}, 32'd0);

        // All five ports requesting single-flit packets
        do_reset(1'b0);
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 5; p++) push_flit(p, 16'(16'h5000 + r * 16 + p), 1);
        repeat (16) step();
        chk("rr_count", {31'b0, glog_idx.size() >= 6}, 32'd1);
        if (glog_idx.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("rr_order", 32'(glog_idx[i]), 32'(i % 5));
                chk("rr_owner", 32'(glog_own[i]), 32'(i % 5));
                if (i > 0) chk("rr_gap", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd2);
            end
        end

        // S locked for 4 flits, W arrives mid-packet
        do_reset(1'b0);
        clear_log();
        for (int i = 0; i < 4; i++) push_flit(1, 16'(16'hB100 + i), (i == 3));
        step(); step();
        push_flit(2, 16'hB200, 1);
        repeat (10) step();
        chk("lock_count", {31'b0, glog_idx.size() == 5}, 32'd1);
        if (glog_idx.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("lock_s", 32'(glog_idx[i]), 32'd1);
            chk("lock_w", 32'(glog_idx[4]), 32'd2);
            chk("lock_w_gap", 32'(glog_cyc[4] - glog_cyc[3]), 32'd2);
        end

        // Backpressure while holding 0xBEEF
        do_reset(1'b0);
        push_flit(0, 16'hBEEF, 0); push_flit(0, 16'h1234, 1);
        step(); chk("bp_c0_grant", {27'b0, grant_o}, 32'd0);
        step(); chk("bp_c1_grant", {27'b0, grant_o}, 32'd1);
                drv_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data",  {16'b0, data_o}, 32'hBEEF);
            chk("bp_hold_valid", {31'b0, valid_o}, 32'd1);
            chk("bp_hold_grant", {27'b0, grant_o}, 32'd0);
        end
        drv_ready = 1'b1;
        step(); chk("bp_rel_grant", {27'b0, grant_o}, 32'd1);
                chk("bp_rel_data", {16'b0, data_o}, 32'hBEEF);
        step(); chk("bp_next_data", {16'b0, data_o}, 32'h1234);
                chk("bp_next_tail", {31'b0, tail_o}, 32'd1);

        // Owner drops its request for two cycles mid-packet
        do_reset(1'b0);
        push_flit(0, 16'hC001, 0); push_flit(0, 16'hC002, 0); push_flit(0, 16'hC003, 1);
        step(); step();
        chk("gap_c1_grant", {27'b0, grant_o}, 32'd1);
        hold[0] = 1'b1;
        step(); chk("gap_c2_grant", {27'b0, grant_o}, 32'd0);
                chk("gap_c2_data", {16'b0, data_o}, 32'hC001);
                chk("gap_c2_busy", {31'b0, busy_o}, 32'd1);
        step(); chk("gap_c3_valid", {31'b0, valid_o}, 32'd0);
                chk("gap_c3_busy", {31'b0, busy_o}, 32'd1);
                chk("gap_c3_grant", {27'b0, grant_o}, 32'd0);
        hold[0] = 1'b0;
        step(); chk("gap_c4_grant", {27'b0, grant_o}, 32'd1);
        step(); chk("gap_c5_data", {16'b0, data_o}, 32'hC002);
        step(); chk("gap_c6_data", {16'b0, data_o}, 32'hC003);
                chk("gap_c6_busy", {31'b0, busy_o}, 32'd0);

        // Asynchronous reset in the middle of a packet
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) push_flit(0, 16'(16'hD001 + i), (i == 3));
        step(); step(); step();
        chk("ar_pre_valid", {31'b0, valid_o}, 32'd1);
        do_reset(1'b1);
        clear_log();
        push_flit(1, 16'hE001, 1); push_flit(0, 16'hE000, 1);
        repeat (8) step();
        chk("ar_count", {31'b0, glog_idx.size() >= 1}, 32'd1);
        if (glog_idx.size() >= 1) chk("ar_first_n", 32'(glog_idx[0]), 32'd0);

        // Randomized traffic and backpressure
        do_reset(1'b0);
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
